line_buffer_scheduler: RTL and testbench
========================================

LINE_BUFFER_SCHEDULER -- requirements
Module: line_buffer_scheduler

Interface
REQ-001 Parameter ADDR_LEN, default 13: width of every BRAM line address.
REQ-002 Parameter LINE_SLOTS, default 8 (power of 2): number of line slots in the circular input buffer.
REQ-003 Parameter CNT_W, default 16: width of the line and window counters.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_start  in  1  one-cycle pulse that latches cfg_* and starts a frame.
REQ-007 cfg_linelen  in  ADDR_LEN  words per line.
REQ-008 cfg_num_lines  in  CNT_W  image lines in the frame.
REQ-009 cfg_kernel  in  4  rows per read window.
REQ-010 cfg_stride  in  4  lines released per window.
REQ-011 wr_conf  out  1  one-cycle pulse that starts the line writer.
REQ-012 wr_st_addr  out  ADDR_LEN  writer start address; valid while wr_conf is high.
REQ-013 wr_done  in  1  pulse: writer finished the current line.
REQ-014 rd_start  out  1  one-cycle pulse that starts a compute window.
REQ-015 rd_base_addr  out  ADDR_LEN  address of the oldest line in the window; valid while rd_start is high.
REQ-016 rd_done  in  1  pulse: compute finished the window.
REQ-017 busy  out  1  frame in progress.
REQ-018 frame_done  out  1  one-cycle pulse at frame end.
REQ-019 cfg_err  out  1  sticky flag: illegal configuration.

Function
REQ-020 cfg_start while busy=1 shall be ignored.
REQ-021 On cfg_start, the configuration is illegal if any of these holds: kernel=0, kernel>LINE_SLOTS-1, stride=0, stride>kernel, num_lines<kernel, or LINE_SLOTS*linelen overflows ADDR_LEN. An illegal configuration shall set cfg_err, leave busy=0 and issue nothing.
REQ-022 A legal cfg_start shall clear cfg_err and the frame counters, set wr_ptr=rd_ptr=0 and count=0, and set busy=1 on the next cycle.
REQ-023 Slot k address = k*linelen. It shall be produced by an accumulator that adds linelen per slot and returns to 0 when the slot index wraps LINE_SLOTS-1 -> 0; no multiplier.
REQ-024 The write FSM shall have states W_IDLE, W_ISSUE and W_WAIT.
REQ-025 W_IDLE -> W_ISSUE when busy=1, lines_written<num_lines and count<LINE_SLOTS.
REQ-026 In W_ISSUE, wr_conf=1 for exactly one cycle with wr_st_addr = address of wr_ptr; the FSM then goes to W_WAIT.
REQ-027 In W_WAIT, on wr_done: count+1, wr_ptr+1 (wrapping), lines_written+1, then go to W_IDLE. At most one write shall be in flight.
REQ-028 wr_done outside W_WAIT shall be ignored.
REQ-029 The read FSM shall have states R_IDLE, R_ISSUE and R_WAIT.
REQ-030 R_IDLE -> R_ISSUE when busy=1 and count>=kernel.
REQ-031 In R_ISSUE, rd_start=1 for one cycle with rd_base_addr = address of rd_ptr; the FSM then goes to R_WAIT.
REQ-032 In R_WAIT, on rd_done: count-stride, rd_ptr+stride (mod LINE_SLOTS), windows_done+1, then go to R_IDLE.
REQ-033 rd_done outside R_WAIT shall be ignored.
REQ-034 wr_done and rd_done accepted in the same cycle shall give count = count+1-stride.
REQ-035 Frame end: windows_done = (num_lines-kernel)/stride+1 (integer division), computed once at cfg_start. On the rd_done that reaches it, frame_done pulses one cycle after acceptance, busy drops the same cycle, count clears to 0 and lines not yet written are not requested.
REQ-036 Full: count=LINE_SLOTS stalls writes and leaves wr_conf low. Empty or count<kernel stalls reads and leaves rd_start low.
REQ-037 wr_conf and rd_start may assert in the same cycle.
REQ-038 Latency: from cfg_start, the first wr_conf shall occur on cycle 2; from the wr_done that makes count=kernel, rd_start shall occur on cycle 2.

Reset
REQ-039 rst shall immediately force outputs and state to: wr_conf=0, rd_start=0, wr_st_addr=0, rd_base_addr=0, busy=0, frame_done=0, cfg_err=0; both FSMs to idle; all counters and pointers to 0.
REQ-040 rst mid-frame shall abandon the frame; wr_done/rd_done arriving afterwards shall be ignored.

Verification
REQ-041 linelen=20, kernel=3, stride=1, num_lines=5, prompt responders -> wr_st_addr 0,20,40,60,80; rd_base_addr 0,20,40; frame_done after the 3rd rd_done.
REQ-042 Same configuration with num_lines=12 and rd_done withheld -> exactly 8 wr_conf, the 9th blocked while count=8; releasing one rd_done -> 9th wr_st_addr=0 (wrap).
REQ-043 kernel=3, stride=2, num_lines=7 -> 3 windows, rd_base_addr 0,40,80.
REQ-044 Force wr_done and rd_done in the same cycle with count=3, stride=1 -> count=3.
REQ-045 kernel=0, or stride=4 with kernel=3 -> cfg_err=1, busy=0, no wr_conf; a following legal cfg_start clears cfg_err.
REQ-046 Assert rst during R_WAIT, then pulse rd_done -> all outputs 0, no frame_done.

Source files
------------

// File: rtl/line_buffer_scheduler.sv
`timescale 1ns/1ps
// Schedules line writes into a circular BRAM line buffer and releases sliding
// read windows of cfg_kernel rows, advancing by cfg_stride lines per window.
//   state   | meaning
//   W_IDLE  | waiting for a free slot and an unwritten line
//   W_ISSUE | wr_conf pulse with the slot start address
//   W_WAIT  | line write in flight, waiting for wr_done
//   R_IDLE  | waiting for kernel lines to be resident
//   R_ISSUE | rd_start pulse with the oldest-line address
//   R_WAIT  | window in flight, waiting for rd_done
module line_buffer_scheduler #(
  parameter int ADDR_LEN   = 13,
  parameter int LINE_SLOTS = 8,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [ADDR_LEN-1:0] cfg_linelen,
  input  logic [CNT_W-1:0]    cfg_num_lines,
  input  logic [3:0]          cfg_kernel,
  input  logic [3:0]          cfg_stride,
  output logic                wr_conf,
  output logic [ADDR_LEN-1:0] wr_st_addr,
  input  logic                wr_done,
  output logic                rd_start,
  output logic [ADDR_LEN-1:0] rd_base_addr,
  input  logic                rd_done,
  output logic                busy,
  output logic                frame_done,
  output logic                cfg_err
);
  localparam int SW = $clog2(LINE_SLOTS);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                busy_q, frame_done_q, cfg_err_q;
  logic [ADDR_LEN-1:0] linelen_q;
  logic [CNT_W-1:0]    num_lines_q, win_total_q, lines_written, windows_done;
  logic [3:0]          kernel_q, stride_q;
  logic [CW-1:0]       count;
  logic [SW-1:0]       wr_ptr, rd_ptr;
  logic [ADDR_LEN-1:0] wr_addr;
  logic [ADDR_LEN-1:0] addr_tab [LINE_SLOTS];

  logic             cfg_go, cfg_bad, addr_ovf, wr_acc, rd_acc, last_rd;
  logic [CNT_W-1:0] win_total_d;

  // Slot addresses are remembered as the writer's accumulator visits them,
  // so the reader can jump by stride slots without a multiplier.
  assign addr_ovf = (cfg_linelen >> (ADDR_LEN - SW)) != '0;
  assign cfg_bad  = (cfg_kernel == 4'd0) || (32'(cfg_kernel) > 32'(LINE_SLOTS - 1)) ||
                    (cfg_stride == 4'd0) || (cfg_stride > cfg_kernel) ||
                    (cfg_num_lines < CNT_W'(cfg_kernel)) || addr_ovf;
  assign cfg_go      = cfg_start && !busy_q;
  assign win_total_d = (cfg_num_lines - CNT_W'(cfg_kernel)) / CNT_W'(cfg_stride) + CNT_W'(1);
  assign wr_acc  = (w_state == W_WAIT) && wr_done;
  assign rd_acc  = (r_state == R_WAIT) && rd_done;
  assign last_rd = rd_acc && ((windows_done + CNT_W'(1)) == win_total_q);

  always_comb begin
    w_next  = w_state;
    wr_conf = 1'b0;
    case (w_state)
      W_IDLE:  if (busy_q && (lines_written < num_lines_q) && (32'(count) < LINE_SLOTS))
                 w_next = W_ISSUE;
      W_ISSUE: begin
        wr_conf = 1'b1;
        w_next  = W_WAIT;
      end
      W_WAIT:  if (wr_done) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    // Frame end abandons any write still pending.
    if (last_rd) w_next = W_IDLE;
  end

  always_comb begin
    r_next   = r_state;
    rd_start = 1'b0;
    case (r_state)
      R_IDLE:  if (busy_q && (32'(count) >= 32'(kernel_q))) r_next = R_ISSUE;
      R_ISSUE: begin
        rd_start = 1'b1;
        r_next   = R_WAIT;
      end
      R_WAIT:  if (rd_done) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      r_state       <= R_IDLE;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
      linelen_q     <= '0;
      num_lines_q   <= '0;
      win_total_q   <= '0;
      kernel_q      <= '0;
      stride_q      <= '0;
      lines_written <= '0;
      windows_done  <= '0;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      wr_addr       <= '0;
      for (int i = 0; i < LINE_SLOTS; i++) addr_tab[i] <= '0;
    end else begin
      w_state      <= w_next;
      r_state      <= r_next;
      frame_done_q <= 1'b0;
      if (cfg_go) begin
        if (cfg_bad) begin
          cfg_err_q <= 1'b1;
        end else begin
          cfg_err_q     <= 1'b0;
          busy_q        <= 1'b1;
          linelen_q     <= cfg_linelen;
          num_lines_q   <= cfg_num_lines;
          kernel_q      <= cfg_kernel;
          stride_q      <= cfg_stride;
          win_total_q   <= win_total_d;
          lines_written <= '0;
          windows_done  <= '0;
          count         <= '0;
          wr_ptr        <= '0;
          rd_ptr        <= '0;
          wr_addr       <= '0;
        end
      end else if (busy_q) begin
        if (w_state == W_ISSUE) addr_tab[wr_ptr] <= wr_addr;
        if (wr_acc) begin
          wr_ptr        <= wr_ptr + SW'(1);
          wr_addr       <= (wr_ptr == SW'(LINE_SLOTS - 1)) ? '0 : wr_addr + linelen_q;
          lines_written <= lines_written + CNT_W'(1);
        end
        if (rd_acc) begin
          rd_ptr       <= rd_ptr + SW'(stride_q);
          windows_done <= windows_done + CNT_W'(1);
        end
        if (last_rd) begin
          count        <= '0;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b1;
        end else begin
          count <= count + CW'(wr_acc) - (rd_acc ? CW'(stride_q) : CW'(0));
        end
      end
    end
  end

  assign wr_st_addr   = wr_conf  ? wr_addr          : '0;
  assign rd_base_addr = rd_start ? addr_tab[rd_ptr] : '0;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_line_buffer_scheduler.sv
`timescale 1ns/1ps
// Bench for line_buffer_scheduler: expected write/read addresses are queued
// from a closed-form slot model and popped as the DUT issues them.
module tb_line_buffer_scheduler;
  localparam int AL = 13;
  localparam int SL = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [AL-1:0] cfg_linelen;
  logic [CW-1:0] cfg_num_lines;
  logic [3:0]    cfg_kernel, cfg_stride;
  logic          wr_conf, wr_done, rd_start, rd_done, busy, frame_done, cfg_err;
  logic [AL-1:0] wr_st_addr, rd_base_addr;

  line_buffer_scheduler #(.ADDR_LEN(AL), .LINE_SLOTS(SL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_linelen(cfg_linelen),
    .cfg_num_lines(cfg_num_lines), .cfg_kernel(cfg_kernel), .cfg_stride(cfg_stride),
    .wr_conf(wr_conf), .wr_st_addr(wr_st_addr), .wr_done(wr_done),
    .rd_start(rd_start), .rd_base_addr(rd_base_addr), .rd_done(rd_done),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int wr_cnt, rd_cnt, fd_cnt, rd_pend, wd_n, k_cur, t_cfg, t_wc, t_wd, t_rd;
  bit wr_auto, rd_auto;
  logic [AL-1:0] exp_wr[$];
  logic [AL-1:0] exp_rd[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {1'b0, wr_conf, rd_start, busy, frame_done, cfg_err, wr_st_addr, rd_base_addr};
  endfunction

  // Output monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (wr_conf) begin
        wr_cnt++;
        if (wr_cnt == 1) t_wc = cyc;
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_st_addr", 32'(wr_st_addr), 32'(exp_wr.pop_front()));
      end
      if (rd_start) begin
        rd_cnt++;
        rd_pend++;
        if (rd_cnt == 1) t_rd = cyc;
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_base_addr", 32'(rd_base_addr), 32'(exp_rd.pop_front()));
      end
      if (wr_done) begin
        wd_n++;
        if (wd_n == k_cur) t_wd = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        chk("fd_busy_low", 32'(busy), 0);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (wr_conf && wr_auto) begin
      @(posedge clk); #1 wr_done = 1'b1;
      @(posedge clk); #1 wr_done = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rd_auto && rd_pend > 0) begin
      rd_pend--;
      @(posedge clk); #1 rd_done = 1'b1;
      @(posedge clk); #1 rd_done = 1'b0;
    end
  end

  task automatic clr();
    wr_cnt = 0; rd_cnt = 0; fd_cnt = 0; rd_pend = 0; wd_n = 0;
    t_wc = 0; t_wd = 0; t_rd = 0;
    exp_wr.delete();
    exp_rd.delete();
  endtask

  task automatic push_exp(input int ll, input int n, input int k, input int s);
    for (int i = 0; i < n; i++) exp_wr.push_back(AL'((i % SL) * ll));
    for (int w = 0; w < (n - k) / s + 1; w++) exp_rd.push_back(AL'(((w * s) % SL) * ll));
  endtask

  task automatic start(input int ll, input int n, input int k, input int s);
    @(posedge clk); #1;
    cfg_linelen = AL'(ll); cfg_num_lines = CW'(n);
    cfg_kernel = 4'(k); cfg_stride = 4'(s);
    cfg_start = 1'b1;
    t_cfg = cyc;
    @(posedge clk); #1 cfg_start = 1'b0;
  endtask

  task automatic wait_fd(input int bound);
    for (int i = 0; i < bound && fd_cnt == 0; i++) @(negedge clk);
    if (fd_cnt == 0) chk("fd_timeout", 0, 1);
  endtask

  task automatic wait_wr(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (wr_conf) break;
    end
    if (i == bound) chk("wr_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_linelen = '0; cfg_num_lines = '0;
    cfg_kernel = '0; cfg_stride = '0; wr_done = 1'b0; rd_done = 1'b0;
    wr_auto = 1'b1; rd_auto = 1'b1; k_cur = 0;
    clr();
    @(negedge clk);
    chk("rst_outs", all_outs(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", all_outs(), 0);

    // Basic frame, latency checks
    clr(); k_cur = 3;
    push_exp(20, 5, 3, 1);
    start(20, 5, 3, 1);
    @(negedge clk);
    chk("busy_on", 32'(busy), 1);
    wait_fd(300);
    repeat (3) @(negedge clk);
    chk("t1_wr_cnt", wr_cnt, 5);
    chk("t1_rd_cnt", rd_cnt, 3);
    chk("t1_fd_cnt", fd_cnt, 1);
    chk("t1_left", exp_wr.size() + exp_rd.size(), 0);
    chk("lat_cfg_wr", t_wc - t_cfg, 2);
    chk("lat_wd_rd", t_rd - t_wd, 2);
    chk("t1_busy_off", 32'(busy), 0);

    // Full buffer with reads withheld, then wrap
    clr(); k_cur = 0; rd_auto = 1'b0;
    push_exp(20, 12, 3, 1);
    start(20, 12, 3, 1);
    repeat (150) @(negedge clk);
    chk("t2_wr_full", wr_cnt, 8);
    chk("t2_rd_held", rd_cnt, 1);
    chk("t2_count", 32'(dut.count), 8);
    rd_auto = 1'b1;
    wait_fd(800);
    repeat (3) @(negedge clk);
    chk("t2_wr_cnt", wr_cnt, 12);
    chk("t2_rd_cnt", rd_cnt, 10);
    chk("t2_left", exp_wr.size() + exp_rd.size(), 0);

    // Stride 2
    clr();
    push_exp(20, 7, 3, 2);
    start(20, 7, 3, 2);
    wait_fd(400);
    repeat (3) @(negedge clk);
    chk("t3_rd_cnt", rd_cnt, 3);
    chk("t3_wr_cnt", wr_cnt, 7);
    chk("t3_left", exp_wr.size() + exp_rd.size(), 0);

    // Simultaneous wr_done/rd_done, then reset during R_WAIT
    clr(); wr_auto = 1'b0; rd_auto = 1'b0;
    for (int i = 0; i < 5; i++) exp_wr.push_back(AL'(i * 20));
    exp_rd.push_back(AL'(0));
    exp_rd.push_back(AL'(20));
    start(20, 12, 3, 1);
    for (int i = 0; i < 4; i++) begin
      wait_wr(40);
      if (i < 3) begin
        @(posedge clk); #1 wr_done = 1'b1;
        @(posedge clk); #1 wr_done = 1'b0;
      end
    end
    chk("t4_rd_issued", rd_cnt, 1);
    @(posedge clk); #1 wr_done = 1'b1; rd_done = 1'b1;
    @(posedge clk); #1 wr_done = 1'b0; rd_done = 1'b0;
    @(negedge clk);
    chk("t4_count_same", 32'(dut.count), 3);
    repeat (4) @(negedge clk);
    chk("t4_wr_cnt", wr_cnt, 5);
    chk("t4_rd_cnt", rd_cnt, 2);
    chk("t4_left", exp_wr.size() + exp_rd.size(), 0);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("rst_async", all_outs(), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rd_done = 1'b1; wr_done = 1'b1;
    @(posedge clk); #1 rd_done = 1'b0; wr_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_outs", all_outs(), 0);
    end
    chk("post_rst_fd", fd_cnt, 0);
    chk("post_rst_count", 32'(dut.count), 0);

    // Illegal configurations
    clr(); wr_auto = 1'b1; rd_auto = 1'b1;
    begin
      int bad_cfg [5][4] = '{'{20, 5, 0, 1}, '{20, 5, 3, 4}, '{1024, 5, 3, 1},
                             '{20, 2, 3, 1}, '{20, 9, 8, 1}};
      for (int i = 0; i < 5; i++) begin
        start(bad_cfg[i][0], bad_cfg[i][1], bad_cfg[i][2], bad_cfg[i][3]);
        repeat (5) @(negedge clk);
        chk("illegal_err", 32'(cfg_err), 1);
        chk("illegal_busy", 32'(busy), 0);
        chk("illegal_wr", wr_cnt, 0);
      end
    end
    push_exp(20, 5, 3, 1);
    start(20, 5, 3, 1);
    @(negedge clk);
    chk("legal_clears_err", 32'(cfg_err), 0);
    chk("legal_busy", 32'(busy), 1);
    repeat (2) @(negedge clk);
    start(20, 5, 0, 1);
    chk("busy_start_ignored", 32'(cfg_err), 0);
    wait_fd(300);
    repeat (3) @(negedge clk);
    chk("t5_wr_cnt", wr_cnt, 5);
    chk("t5_rd_cnt", rd_cnt, 3);
    chk("t5_left", exp_wr.size() + exp_rd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
